// File: rtl/mem_arbiter.sv
// Two-requester round-robin arbiter onto a single memory port.
// Registered memory command, read return with timeout fallback.
module mem_arbiter #(
   parameter int ADDR_WIDTH    = 20,
   parameter int DATA_WIDTH    = 16,
   parameter int TIMEOUT_WIDTH = 8,
   localparam int BE_WIDTH     = DATA_WIDTH / 8
) (
   input  logic                  clock,
   input  logic                  reset_n,
   input  logic [ADDR_WIDTH-1:0] m0_address,
   input  logic [BE_WIDTH-1:0]   m0_byteenable,
   input  logic [DATA_WIDTH-1:0] m0_writedata,
   input  logic                  m0_read,
   input  logic                  m0_write,
   output logic                  m0_waitrequest,
   output logic [DATA_WIDTH-1:0] m0_readdata,
   output logic                  m0_readdataready,
   input  logic [ADDR_WIDTH-1:0] m1_address,
   input  logic [BE_WIDTH-1:0]   m1_byteenable,
   input  logic [DATA_WIDTH-1:0] m1_writedata,
   input  logic                  m1_read,
   input  logic                  m1_write,
   output logic                  m1_waitrequest,
   output logic [DATA_WIDTH-1:0] m1_readdata,
   output logic                  m1_readdataready,
   output logic [ADDR_WIDTH-1:0] address,
   output logic [BE_WIDTH-1:0]   byteenable,
   output logic                  read,
   output logic                  write,
   output logic [DATA_WIDTH-1:0] writedata,
   input  logic [DATA_WIDTH-1:0] readdata,
   input  logic                  readdataready,
   input  logic                  waitrequest,
   output logic                  read_timeout
);

   typedef enum logic [1:0] {
      IDLE,
      WRITE,
      READ_REQ,
      READ_WAIT
   } state_t;

   state_t                   state, state_nxt;
   logic                     grant, grant_nxt;
   logic                     prio, prio_nxt;
   logic [ADDR_WIDTH-1:0]    addr_nxt;
   logic [BE_WIDTH-1:0]      be_nxt;
   logic [DATA_WIDTH-1:0]    wd_nxt;
   logic                     rd_nxt, wr_nxt;
   logic [DATA_WIDTH-1:0]    rdata0_nxt, rdata1_nxt;
   logic                     rdr0_nxt, rdr1_nxt;
   logic                     to_nxt;
   logic [TIMEOUT_WIDTH-1:0] cnt, cnt_nxt;
   logic                     ret_en;
   logic [DATA_WIDTH-1:0]    ret_data;

   logic                     req0, req1, sel, sel_wr;
   logic [ADDR_WIDTH-1:0]    sel_addr;
   logic [BE_WIDTH-1:0]      sel_be;
   logic [DATA_WIDTH-1:0]    sel_wd;
   logic                     accept;

   assign req0 = m0_read | m0_write;
   assign req1 = m1_read | m1_write;
   // prio names the requester that wins a tie
   assign sel      = (req0 & req1) ? prio : req1;
   assign sel_wr   = sel ? m1_write : m0_write;
   assign sel_addr = sel ? m1_address : m0_address;
   assign sel_be   = sel ? m1_byteenable : m0_byteenable;
   assign sel_wd   = sel ? m1_writedata : m0_writedata;

   assign accept = ((state == WRITE) || (state == READ_REQ)) && !waitrequest;
   assign m0_waitrequest = !(accept && !grant);
   assign m1_waitrequest = !(accept && grant);

   always_comb begin
      state_nxt = state;
      grant_nxt = grant;
      prio_nxt  = prio;
      addr_nxt  = address;
      be_nxt    = byteenable;
      wd_nxt    = writedata;
      rd_nxt    = read;
      wr_nxt    = write;
      cnt_nxt   = cnt;
      to_nxt    = read_timeout;
      ret_en    = 1'b0;
      ret_data  = readdata;
      unique case (state)
         IDLE: begin
            if (req0 | req1) begin
               grant_nxt = sel;
               prio_nxt  = ~sel;
               addr_nxt  = sel_addr;
               be_nxt    = sel_be;
               wd_nxt    = sel_wd;
               if (sel_wr) begin
                  wr_nxt    = 1'b1;
                  state_nxt = WRITE;
               end else begin
                  rd_nxt    = 1'b1;
                  state_nxt = READ_REQ;
               end
            end
         end
         WRITE: begin
            if (!waitrequest) begin
               wr_nxt    = 1'b0;
               state_nxt = IDLE;
            end
         end
         READ_REQ: begin
            if (!waitrequest) begin
               rd_nxt    = 1'b0;
               cnt_nxt   = '0;
               state_nxt = READ_WAIT;
            end
         end
         READ_WAIT: begin
            if (readdataready) begin
               ret_en    = 1'b1;
               state_nxt = IDLE;
            end else if (cnt == '1) begin
               ret_en    = 1'b1;
               ret_data  = '1;
               to_nxt    = 1'b1;
               state_nxt = IDLE;
            end else begin
               cnt_nxt = cnt + 1'b1;
            end
         end
      endcase
      rdata0_nxt = m0_readdata;
      rdata1_nxt = m1_readdata;
      rdr0_nxt   = ret_en & ~grant;
      rdr1_nxt   = ret_en & grant;
      if (ret_en) begin
         if (grant) rdata1_nxt = ret_data;
         else       rdata0_nxt = ret_data;
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state            <= IDLE;
         grant            <= 1'b0;
         prio             <= 1'b0;
         address          <= '0;
         byteenable       <= '0;
         writedata        <= '0;
         read             <= 1'b0;
         write            <= 1'b0;
         m0_readdata      <= '0;
         m1_readdata      <= '0;
         m0_readdataready <= 1'b0;
         m1_readdataready <= 1'b0;
         read_timeout     <= 1'b0;
         cnt              <= '0;
      end else begin
         state            <= state_nxt;
         grant            <= grant_nxt;
         prio             <= prio_nxt;
         address          <= addr_nxt;
         byteenable       <= be_nxt;
         writedata        <= wd_nxt;
         read             <= rd_nxt;
         write            <= wr_nxt;
         m0_readdata      <= rdata0_nxt;
         m1_readdata      <= rdata1_nxt;
         m0_readdataready <= rdr0_nxt;
         m1_readdataready <= rdr1_nxt;
         read_timeout     <= to_nxt;
         cnt              <= cnt_nxt;
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed and randomized bench for mem_arbiter.
// A transaction-level model predicts grant order and returns.
module tb_mem_arbiter;

   logic        clock = 1'b0;
   logic        reset_n;
   logic [19:0] m0_address, m1_address, address;
   logic [1:0]  m0_byteenable, m1_byteenable, byteenable;
   logic [15:0] m0_writedata, m1_writedata, writedata;
   logic        m0_read, m0_write, m1_read, m1_write;
   logic        m0_waitrequest, m1_waitrequest;
   logic [15:0] m0_readdata, m1_readdata, readdata;
   logic        m0_readdataready, m1_readdataready;
   logic        read, write, readdataready, waitrequest;
   logic        read_timeout;

   int n_chk = 0;
   int n_fail = 0;

   typedef struct {
      bit          rd;
      bit          wr;
      logic [19:0] a;
      logic [1:0]  be;
      logic [15:0] d;
   } cmd_t;

   bit          last;
   bit          exp_to;
   logic [15:0] exp_rdata [2];

   mem_arbiter dut (
      .clock(clock), .reset_n(reset_n),
      .m0_address(m0_address), .m0_byteenable(m0_byteenable),
      .m0_writedata(m0_writedata), .m0_read(m0_read),
      .m0_write(m0_write), .m0_waitrequest(m0_waitrequest),
      .m0_readdata(m0_readdata), .m0_readdataready(m0_readdataready),
      .m1_address(m1_address), .m1_byteenable(m1_byteenable),
      .m1_writedata(m1_writedata), .m1_read(m1_read),
      .m1_write(m1_write), .m1_waitrequest(m1_waitrequest),
      .m1_readdata(m1_readdata), .m1_readdataready(m1_readdataready),
      .address(address), .byteenable(byteenable), .read(read),
      .write(write), .writedata(writedata), .readdata(readdata),
      .readdataready(readdataready), .waitrequest(waitrequest),
      .read_timeout(read_timeout)
   );

   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic cmd_t mk(input bit n, input int kind,
                               input logic [19:0] a, input logic [15:0] d,
                               input logic [1:0] be);
      cmd_t c;
      c.wr = (kind != 1);
      c.rd = (kind != 0);
      c.a  = a;
      c.d  = d;
      c.be = be;
      if (n) c.a[0] = 1'b1;
      else   c.a[0] = 1'b0;
      return c;
   endfunction

   task automatic set_req(input bit n, input cmd_t c);
      if (n) begin
         m1_address = c.a; m1_byteenable = c.be; m1_writedata = c.d;
         m1_read = c.rd; m1_write = c.wr;
      end else begin
         m0_address = c.a; m0_byteenable = c.be; m0_writedata = c.d;
         m0_read = c.rd; m0_write = c.wr;
      end
   endtask

   task automatic clr_req(input bit n);
      if (n) begin m1_read = 0; m1_write = 0; end
      else begin m0_read = 0; m0_write = 0; end
   endtask

   task automatic scramble(input bit n);
      if (n) begin
         m1_address = 20'($urandom); m1_writedata = 16'($urandom);
         m1_byteenable = 2'($urandom);
      end else begin
         m0_address = 20'($urandom); m0_writedata = 16'($urandom);
         m0_byteenable = 2'($urandom);
      end
   endtask

   task automatic wait_strobe(output bit ok);
      int k = 0;
      while (!(read | write) && k < 10) begin
         chk("idle_wreq", 32'({m1_waitrequest, m0_waitrequest}), 32'h3);
         @(negedge clock);
         k++;
      end
      ok = (k < 10);
      chk("grant_seen", 32'(ok), 32'h1);
   endtask

   task automatic chk_cmd(input cmd_t c);
      chk("mem_addr", 32'(address), 32'(c.a));
      chk("mem_be", 32'(byteenable), 32'(c.be));
      chk("mem_wdata", 32'(writedata), 32'(c.d));
      chk("mem_write", 32'(write), 32'(c.wr));
      chk("mem_read", 32'(read), 32'(!c.wr && c.rd));
   endtask

   task automatic chk_ret(input bit n, input bit pulse);
      chk("rdr0", 32'(m0_readdataready), 32'(pulse && !n));
      chk("rdr1", 32'(m1_readdataready), 32'(pulse && n));
      chk("rdata0", 32'(m0_readdata), 32'(exp_rdata[0]));
      chk("rdata1", 32'(m1_readdata), 32'(exp_rdata[1]));
   endtask

   task automatic serve(input bit n, input cmd_t c, input int ws,
                        input int lat, input logic [15:0] rd);
      bit ok;
      wait_strobe(ok);
      if (!ok) return;
      chk_cmd(c);
      for (int i = 0; i < ws; i++) begin
         waitrequest = 1;
         readdataready = 1'($urandom);
         scramble(n);
         #1;
         chk("hold_wreq", 32'({m1_waitrequest, m0_waitrequest}), 32'h3);
         @(negedge clock);
         chk_cmd(c);
         chk_ret(n, 0);
      end
      readdataready = 0;
      waitrequest = 0;
      #1;
      chk("acc_wreq_n", 32'(n ? m1_waitrequest : m0_waitrequest), 32'h0);
      chk("acc_wreq_o", 32'(n ? m0_waitrequest : m1_waitrequest), 32'h1);
      @(negedge clock);
      waitrequest = 1;
      clr_req(n);
      chk("after_wr", 32'(write), 32'h0);
      chk("after_rd", 32'(read), 32'h0);
      if (!c.wr) begin
         for (int i = 0; i < lat; i++) begin
            @(negedge clock);
            chk_ret(n, 0);
         end
         readdata = rd;
         readdataready = 1;
         @(negedge clock);
         readdataready = 0;
         exp_rdata[n] = rd;
         chk_ret(n, 1);
         @(negedge clock);
         chk_ret(n, 0);
      end
      chk("timeout_flag", 32'(read_timeout), 32'(exp_to));
      last = n;
   endtask

   task automatic run_pair(input bit a0, input bit a1, input cmd_t c0,
                           input cmd_t c1, input logic [15:0] r0,
                           input logic [15:0] r1, input int ws,
                           input int lat);
      bit first;
      if (a0) set_req(0, c0);
      if (a1) set_req(1, c1);
      first = (a0 && a1) ? !last : a1;
      if (first) serve(1, c1, ws, lat, r1);
      else       serve(0, c0, ws, lat, r0);
      if (a0 && a1) begin
         if (first) serve(0, c0, ws, lat, r0);
         else       serve(1, c1, ws, lat, r1);
      end
   endtask

   initial begin
      cmd_t c0, c1;
      bit ok, a0, a1;
      int cnt;
      reset_n = 0;
      m0_address = 0; m0_byteenable = 0; m0_writedata = 0;
      m1_address = 0; m1_byteenable = 0; m1_writedata = 0;
      m0_read = 0; m0_write = 0; m1_read = 0; m1_write = 0;
      readdata = 0; readdataready = 0; waitrequest = 1;
      last = 1; exp_to = 0;
      exp_rdata[0] = 0; exp_rdata[1] = 0;
      #1;
      chk("rst_read", 32'(read), 32'h0);
      chk("rst_write", 32'(write), 32'h0);
      chk("rst_addr", 32'(address), 32'h0);
      chk("rst_wdata", 32'(writedata), 32'h0);
      chk("rst_to", 32'(read_timeout), 32'h0);
      chk_ret(0, 0);
      @(negedge clock);
      reset_n = 1;
      @(negedge clock);

      c0 = mk(0, 1, 20'h00010, 16'h0, 2'b11);
      c1 = mk(1, 1, 20'h00021, 16'h0, 2'b11);
      run_pair(1, 1, c0, c1, 16'h1111, 16'h2222, 0, 2);

      c1 = mk(1, 0, 20'h00123, 16'hBEEF, 2'b11);
      run_pair(0, 1, c0, c1, 0, 0, 0, 0);

      c0 = mk(0, 0, 20'h0ABC4, 16'h5A5A, 2'b01);
      run_pair(1, 0, c0, c1, 0, 0, 5, 0);

      c1 = mk(1, 2, 20'h00771, 16'hC0DE, 2'b10);
      run_pair(0, 1, c0, c1, 0, 0, 1, 0);

      for (int it = 0; it < 40; it++) begin
         a0 = 1'($urandom);
         a1 = 1'($urandom);
         if (!a0 && !a1) a0 = 1;
         c0 = mk(0, int'($urandom_range(0, 2)), 20'($urandom),
                 16'($urandom), 2'($urandom));
         c1 = mk(1, int'($urandom_range(0, 2)), 20'($urandom),
                 16'($urandom), 2'($urandom));
         run_pair(a0, a1, c0, c1, 16'($urandom), 16'($urandom),
                  int'($urandom_range(0, 3)), int'($urandom_range(0, 5)));
      end

      c1 = mk(1, 1, 20'h00301, 16'h0, 2'b11);
      set_req(1, c1);
      wait_strobe(ok);
      chk_cmd(c1);
      waitrequest = 0;
      @(negedge clock);
      waitrequest = 1;
      clr_req(1);
      cnt = 0;
      while (!m1_readdataready && cnt < 400) begin
         @(negedge clock);
         cnt++;
      end
      chk("to_window", 32'(cnt >= 255 && cnt <= 256), 32'h1);
      exp_rdata[1] = 16'hFFFF;
      exp_to = 1;
      chk_ret(1, 1);
      chk("to_flag", 32'(read_timeout), 32'h1);
      last = 1;
      @(negedge clock);
      chk_ret(1, 0);

      c0 = mk(0, 1, 20'h00400, 16'h0, 2'b11);
      run_pair(1, 0, c0, c1, 16'h3C3C, 0, 0, 1);
      chk("to_sticky", 32'(read_timeout), 32'h1);

      c0 = mk(0, 1, 20'h00500, 16'h0, 2'b11);
      set_req(0, c0);
      wait_strobe(ok);
      waitrequest = 0;
      @(negedge clock);
      waitrequest = 1;
      clr_req(0);
      @(negedge clock);
      @(negedge clock);
      reset_n = 0;
      #1;
      exp_rdata[0] = 0;
      exp_rdata[1] = 0;
      exp_to = 0;
      last = 1;
      chk("mid_rst_read", 32'(read), 32'h0);
      chk("mid_rst_addr", 32'(address), 32'h0);
      chk("mid_rst_to", 32'(read_timeout), 32'h0);
      chk_ret(0, 0);
      @(negedge clock);
      reset_n = 1;
      readdata = 16'h7777;
      readdataready = 1;
      @(negedge clock);
      readdataready = 0;
      chk_ret(0, 0);
      @(negedge clock);
      chk_ret(0, 0);

      c0 = mk(0, 0, 20'h00600, 16'h1234, 2'b11);
      c1 = mk(1, 0, 20'h00701, 16'h4321, 2'b11);
      run_pair(1, 1, c0, c1, 0, 0, 0, 0);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
